// File: rtl/sram_frame_pkg.sv
// Shared types and frame constants for the SRAM frame buffer port.
// One SRAM word packs two horizontally adjacent pixels.
package sram_frame_pkg;

  localparam int unsigned N_DEFAULT   = 640;
  localparam int unsigned M_DEFAULT   = 480;
  localparam int unsigned PIX_DEFAULT = 8;
  localparam int unsigned FRAME_PIX   = N_DEFAULT * M_DEFAULT;
  localparam int unsigned WORD_WIDTH  = 2 * PIX_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } mode_e;

  // Write request wins over read request when both are asserted.
  function automatic mode_e mode_sel(input logic we_n, input logic oe_n);
    mode_e m;
    if (!we_n) begin
      m = WRITE;
    end else if (!oe_n) begin
      m = READ;
    end else begin
      m = IDLE;
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// Read path: byte select travels with the address into the SRAM,
// then the selected byte of the returned word is registered out.
module sram_read_pipe #(
  parameter int unsigned PIX_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_inc,
  input  logic                   i_sel,
  input  logic [2*PIX_WIDTH-1:0] i_sram_dq,
  output logic [PIX_WIDTH-1:0]   o_pix,
  output logic                   o_pix_valid
);

  logic                 v1_r;
  logic                 sel_r;
  logic                 valid_r;
  logic [PIX_WIDTH-1:0] pix_r;

  // Stage 1 tracks the outstanding address, stage 2 captures the data byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_r    <= 1'b0;
      sel_r   <= 1'b0;
      valid_r <= 1'b0;
      pix_r   <= {PIX_WIDTH{1'b0}};
    end else if (i_flush) begin
      v1_r    <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      v1_r    <= i_inc;
      valid_r <= v1_r;
      if (i_inc) begin
        sel_r <= i_sel;
      end
      if (v1_r) begin
        pix_r <= sel_r ? i_sram_dq[2*PIX_WIDTH-1:PIX_WIDTH] : i_sram_dq[PIX_WIDTH-1:0];
      end
    end
  end

  assign o_pix       = pix_r;
  assign o_pix_valid = valid_r;

endmodule

// File: rtl/sram_frame_port.sv
// Frame buffer port for an external 16-bit async SRAM: packs pixel pairs
// into words during write frames and streams pixels back during read frames.
module sram_frame_port
  import sram_frame_pkg::*;
#(
  parameter int unsigned N          = N_DEFAULT,
  parameter int unsigned M          = M_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned PIX_WIDTH  = PIX_DEFAULT,
  parameter int unsigned PCNT_WIDTH = 19
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_WE_n,
  input  logic                   i_OE_n,
  input  logic                   i_addr_inc,
  input  logic                   i_pix_valid,
  input  logic [PIX_WIDTH-1:0]   i_pix_data,
  input  logic [2*PIX_WIDTH-1:0] i_sram_dq,
  output logic [ADDR_WIDTH-1:0]  o_sram_addr,
  output logic [2*PIX_WIDTH-1:0] o_sram_dq,
  output logic                   o_sram_dq_oe,
  output logic                   o_sram_we_n,
  output logic                   o_sram_oe_n,
  output logic                   o_sram_ce_n,
  output logic                   o_sram_lb_n,
  output logic                   o_sram_ub_n,
  output logic [PIX_WIDTH-1:0]   o_pix,
  output logic                   o_pix_valid,
  output logic                   o_frame_done
);

  localparam logic [PCNT_WIDTH-1:0] P_LAST = PCNT_WIDTH'(N * M - 1);

  mode_e                  mode_r;
  mode_e                  mode_nxt_s;
  logic                   mode_chg_s;
  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic                   step_s;
  logic                   wrap_s;
  logic [PCNT_WIDTH-1:0]  p_r;
  logic                   pend_r;
  logic [PIX_WIDTH-1:0]   lo_r;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [2*PIX_WIDTH-1:0] dq_r;
  logic                   dq_oe_r;
  logic                   we_n_r;
  logic                   oe_n_r;
  logic                   en_n_r;
  logic                   frame_done_r;

  // Accept pixels / strobes only while settled in a mode; the transition cycle is dead.
  always_comb begin
    mode_nxt_s = mode_sel(i_WE_n, i_OE_n);
    mode_chg_s = (mode_nxt_s != mode_r);
    wr_acc_s   = (mode_r == WRITE) && !mode_chg_s && i_pix_valid;
    rd_acc_s   = (mode_r == READ) && !mode_chg_s && i_addr_inc;
    step_s     = wr_acc_s || rd_acc_s;
    wrap_s     = step_s && (p_r == P_LAST);
  end

  // Mode FSM, pixel index, write packing and SRAM strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_r       <= IDLE;
      p_r          <= {PCNT_WIDTH{1'b0}};
      pend_r       <= 1'b0;
      lo_r         <= {PIX_WIDTH{1'b0}};
      addr_r       <= {ADDR_WIDTH{1'b0}};
      dq_r         <= {(2*PIX_WIDTH){1'b0}};
      dq_oe_r      <= 1'b0;
      we_n_r       <= 1'b1;
      oe_n_r       <= 1'b1;
      en_n_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      mode_r       <= mode_nxt_s;
      en_n_r       <= (mode_nxt_s == IDLE);
      oe_n_r       <= (mode_nxt_s != READ);
      we_n_r       <= 1'b1;
      dq_oe_r      <= 1'b0;
      frame_done_r <= wrap_s;
      if (mode_chg_s) begin
        p_r    <= {PCNT_WIDTH{1'b0}};
        pend_r <= 1'b0;
      end else if (step_s) begin
        p_r <= wrap_s ? {PCNT_WIDTH{1'b0}} : p_r + 1'b1;
      end
      if (wr_acc_s) begin
        if (!p_r[0]) begin
          lo_r   <= i_pix_data;
          pend_r <= 1'b1;
        end else if (pend_r) begin
          addr_r  <= ADDR_WIDTH'(p_r[PCNT_WIDTH-1:1]);
          dq_r    <= {i_pix_data, lo_r};
          we_n_r  <= 1'b0;
          dq_oe_r <= 1'b1;
          pend_r  <= 1'b0;
        end
      end else if (rd_acc_s) begin
        addr_r <= ADDR_WIDTH'(p_r[PCNT_WIDTH-1:1]);
      end
    end
  end

  sram_read_pipe #(
    .PIX_WIDTH (PIX_WIDTH)
  ) u_read_pipe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (mode_chg_s),
    .i_inc       (rd_acc_s),
    .i_sel       (p_r[0]),
    .i_sram_dq   (i_sram_dq),
    .o_pix       (o_pix),
    .o_pix_valid (o_pix_valid)
  );

  assign o_sram_addr  = addr_r;
  assign o_sram_dq    = dq_r;
  assign o_sram_dq_oe = dq_oe_r;
  assign o_sram_we_n  = we_n_r;
  assign o_sram_oe_n  = oe_n_r;
  assign o_sram_ce_n  = en_n_r;
  assign o_sram_lb_n  = en_n_r;
  assign o_sram_ub_n  = en_n_r;
  assign o_frame_done = frame_done_r;

endmodule

// File: tb/tb_sram_frame_port.sv
// Scoreboard bench for sram_frame_port on a reduced 16x8 frame with a behavioural SRAM.
module tb_sram_frame_port;

  localparam int N     = 16;
  localparam int M     = 8;
  localparam int FP    = N * M;
  localparam int WORDS = FP / 2;
  localparam int WB    = $clog2(WORDS);

  typedef struct { int cyc; logic [19:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic [7:0] pix; } rd_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_WE_n = 1'b1;
  logic        i_OE_n = 1'b1;
  logic        i_addr_inc = 1'b0;
  logic        i_pix_valid = 1'b0;
  logic [7:0]  i_pix_data = 8'h00;
  logic [15:0] sram_dq_in;
  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;
  logic        o_sram_dq_oe, o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n;
  logic [7:0]  o_pix;
  logic        o_pix_valid, o_frame_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_mode = 0;
  logic mem_clr = 1'b1;
  logic [15:0] mem [WORDS];
  logic [15:0] ref_word [WORDS];
  wr_t exp_wr_q[$];
  rd_t exp_rd_q[$];
  int  exp_done_q[$];

  sram_frame_port #(.N(N), .M(M), .ADDR_WIDTH(20), .PIX_WIDTH(8), .PCNT_WIDTH(19)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_WE_n(i_WE_n), .i_OE_n(i_OE_n),
    .i_addr_inc(i_addr_inc), .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data),
    .i_sram_dq(sram_dq_in), .o_sram_addr(o_sram_addr), .o_sram_dq(o_sram_dq),
    .o_sram_dq_oe(o_sram_dq_oe), .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n),
    .o_pix(o_pix), .o_pix_valid(o_pix_valid), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  // Cycle counter and expected mode (write request has priority)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_rst) exp_mode <= 0;
    else if (!i_WE_n) exp_mode <= 1;
    else if (!i_OE_n) exp_mode <= 2;
    else exp_mode <= 0;
  end

  // Behavioural asynchronous SRAM
  assign sram_dq_in = (!o_sram_oe_n && !o_sram_ce_n) ? mem[o_sram_addr[WB-1:0]] : 16'h0000;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 16'h0000;
    end else if (!o_sram_we_n && !o_sram_ce_n) begin
      mem[o_sram_addr[WB-1:0]] <= o_sram_dq;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, a pixel or a frame pulse
  always @(negedge clk) begin
    if (!i_rst) begin
      chk("ce_n", {31'd0, o_sram_ce_n}, {31'd0, exp_mode == 0});
      chk("lb_n", {31'd0, o_sram_lb_n}, {31'd0, exp_mode == 0});
      chk("ub_n", {31'd0, o_sram_ub_n}, {31'd0, exp_mode == 0});
      chk("oe_n", {31'd0, o_sram_oe_n}, {31'd0, exp_mode != 2});
      if (!o_sram_we_n && exp_wr_q.size() > 0) begin
        wr_t w;
        w = exp_wr_q.pop_front();
        chk("wr_cycle", cyc, w.cyc);
        chk("wr_addr", {12'd0, o_sram_addr}, {12'd0, w.addr});
        chk("wr_data", {16'd0, o_sram_dq}, {16'd0, w.data});
        chk("wr_dq_oe", {31'd0, o_sram_dq_oe}, 32'd1);
      end else begin
        chk("we_n_spurious", {31'd0, o_sram_we_n}, 32'd1);
        chk("dq_oe_idle", {31'd0, o_sram_dq_oe}, 32'd0);
      end
      if (o_pix_valid && exp_rd_q.size() > 0) begin
        rd_t r;
        r = exp_rd_q.pop_front();
        chk("rd_cycle", cyc, r.cyc);
        chk("rd_pix", {24'd0, o_pix}, {24'd0, r.pix});
      end else begin
        chk("pix_valid_spurious", {31'd0, o_pix_valid}, 32'd0);
      end
      if (o_frame_done && exp_done_q.size() > 0) begin
        chk("frame_done_cycle", cyc, exp_done_q.pop_front());
      end else begin
        chk("frame_done_spurious", {31'd0, o_frame_done}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] px[$], input bit gaps, input bit both_low);
    int pidx;
    logic [7:0] lo;
    i_WE_n = 1'b0;
    i_OE_n = both_low ? 1'b0 : 1'b1;
    i_pix_valid = 1'b0;
    tick();
    pidx = 0;
    lo = 8'h00;
    foreach (px[k]) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          i_pix_valid = 1'b0;
          tick();
        end
      end
      i_pix_valid = 1'b1;
      i_pix_data = px[k];
      if (pidx % 2 == 0) begin
        lo = px[k];
      end else begin
        ref_word[pidx / 2] = {px[k], lo};
        exp_wr_q.push_back('{cyc + 1, 20'(pidx / 2), {px[k], lo}});
      end
      if (pidx == FP - 1) begin
        exp_done_q.push_back(cyc + 1);
        pidx = 0;
      end else begin
        pidx++;
      end
      tick();
    end
    i_pix_valid = 1'b0;
    i_WE_n = 1'b1;
    i_OE_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_read(input int n, input bit gaps);
    int pidx;
    logic [15:0] w;
    i_WE_n = 1'b1;
    i_OE_n = 1'b0;
    i_addr_inc = 1'b0;
    tick();
    pidx = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          i_addr_inc = 1'b0;
          tick();
        end
      end
      i_addr_inc = 1'b1;
      w = ref_word[pidx / 2];
      exp_rd_q.push_back('{cyc + 2, (pidx % 2 == 1) ? w[15:8] : w[7:0]});
      if (pidx == FP - 1) begin
        exp_done_q.push_back(cyc + 1);
        pidx = 0;
      end else begin
        pidx++;
      end
      tick();
    end
    i_addr_inc = 1'b0;
    repeat (3) tick();
    i_OE_n = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    logic [7:0] q[$];
    for (int i = 0; i < WORDS; i++) ref_word[i] = 16'h0000;
    i_rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_addr", {12'd0, o_sram_addr}, 32'd0);
    chk("rst_dq", {16'd0, o_sram_dq}, 32'd0);
    chk("rst_dq_oe", {31'd0, o_sram_dq_oe}, 32'd0);
    chk("rst_we_n", {31'd0, o_sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, o_sram_oe_n}, 32'd1);
    chk("rst_ce_n", {31'd0, o_sram_ce_n}, 32'd1);
    chk("rst_lb_n", {31'd0, o_sram_lb_n}, 32'd1);
    chk("rst_ub_n", {31'd0, o_sram_ub_n}, 32'd1);
    chk("rst_pix", {24'd0, o_pix}, 32'd0);
    chk("rst_pix_valid", {31'd0, o_pix_valid}, 32'd0);
    chk("rst_frame_done", {31'd0, o_frame_done}, 32'd0);
    tick();
    i_rst = 1'b0;
    mem_clr = 1'b0;
    tick();

    // Single pair, then read it back with two consecutive strobes
    q = '{8'h11, 8'h22};
    do_write(q, 1'b0, 1'b0);
    do_read(2, 1'b0);

    // Both requests low behaves as write
    q = '{8'h33, 8'h44, 8'h55, 8'h66};
    do_write(q, 1'b0, 1'b1);

    // Three pixels then exit: third byte discarded
    q = '{8'hA1, 8'hB2, 8'hC3};
    do_write(q, 1'b0, 1'b0);
    do_read(4, 1'b0);

    // Reset in the odd-pixel cycle cancels the pending word
    i_WE_n = 1'b0;
    tick();
    i_pix_valid = 1'b1;
    i_pix_data = 8'h5A;
    tick();
    i_pix_data = 8'hA5;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_pix_valid = 1'b0;
    i_WE_n = 1'b1;
    repeat (3) tick();

    // Full frame write plus wrap, then full frame read plus wrap
    q.delete();
    for (int i = 0; i < FP + 2; i++) q.push_back(8'($urandom));
    do_write(q, 1'b1, 1'b0);
    do_read(FP + 3, 1'b1);

    // Randomized mode sequence
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        q.delete();
        for (int i = 0; i < int'($urandom_range(1, 40)); i++) q.push_back(8'($urandom));
        do_write(q, 1'b1, 1'($urandom_range(0, 1)));
      end else begin
        do_read(int'($urandom_range(1, 40)), 1'b1);
      end
    end
    do_read(FP, 1'b1);

    repeat (4) tick();
    chk("wr_queue_drained", exp_wr_q.size(), 32'd0);
    chk("rd_queue_drained", exp_rd_q.size(), 32'd0);
    chk("done_queue_drained", exp_done_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_frame_port.md
# sram_frame_port

Owns the external 16-bit asynchronous SRAM that holds one frame of 8-bit pixels. Sits directly downstream of the control signal generator: consumes its active-low write/read enables and address-increment strobe, packs the PRNG-converter pixel stream two-per-word into the SRAM during write frames, and streams pixels back out to the VGA colour path during read frames. One SRAM word holds two horizontally adjacent pixels: even pixel in the low byte, odd pixel in the high byte.

## Interface
- N, 640, horizontal pixels per line
- M, 480, lines per frame
- ADDR_WIDTH, 20, SRAM word-address width
- PIX_WIDTH, 8, bits per pixel; SRAM word is 2*PIX_WIDTH
- PCNT_WIDTH, 19, pixel-index counter width; must hold N*M-1

- i_clk  in  1  pixel clock
- i_rst  in  1  synchronous, active-high reset
- i_WE_n  in  1  frame write request, low = write mode
- i_OE_n  in  1  frame read request, low = read mode
- i_addr_inc  in  1  read mode: VGA needs one pixel (active region)
- i_pix_valid  in  1  write mode: i_pix_data valid this cycle
- i_pix_data  in  PIX_WIDTH  pixel to store
- i_sram_dq  in  2*PIX_WIDTH  SRAM data bus, input side
- o_sram_addr  out  ADDR_WIDTH  SRAM word address
- o_sram_dq  out  2*PIX_WIDTH  SRAM data bus, output side
- o_sram_dq_oe  out  1  high = FPGA drives the DQ bus
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active low
- o_pix  out  PIX_WIDTH  pixel read back
- o_pix_valid  out  1  o_pix valid
- o_frame_done  out  1  one-cycle pulse when pixel index wraps

## Operation
- Single clock domain, synchronous active-high reset; all outputs registered.
- Mode FSM states: IDLE, WRITE, READ. Evaluated each cycle: i_WE_n==0 -> WRITE; else i_OE_n==0 -> READ; else IDLE. Write has priority when both low.
- Each mode change (including into IDLE) clears pixel index p, the pending-byte flag, and the read pipeline; an unpaired write byte is discarded, never written.
- Address: o_sram_addr = p[PCNT_WIDTH-1:1], zero-extended; p[0] selects the byte.
- WRITE: on i_pix_valid with p[0]==0, latch low byte; with p[0]==1, form word {i_pix_data, low byte} and issue one write cycle next clock. p increments per valid pixel.
- READ: on i_addr_inc, present address for p, sample i_sram_dq one cycle later, output byte p[0] one cycle after that; p increments per strobe.
- Wrap: p==N*M-1 and incrementing -> p=0, o_frame_done=1 for that next cycle. Write frame terminates only when i_WE_n rises.
- ce_n low, lb_n/ub_n low whenever mode != IDLE; high in IDLE.

## Timing
- Reset values: o_sram_addr=0, o_sram_dq=0, o_sram_dq_oe=0, o_sram_we_n=1, o_sram_oe_n=1, o_sram_ce_n=1, o_sram_lb_n=1, o_sram_ub_n=1, o_pix=0, o_pix_valid=0, o_frame_done=0; FSM IDLE, p=0.
- Write: odd pixel accepted cycle t -> cycle t+1 has o_sram_addr, o_sram_dq, o_sram_dq_oe=1 and o_sram_we_n=0 all for exactly one cycle; o_sram_oe_n=1 throughout WRITE. Back-to-back pixel pairs sustain one word per two cycles.
- Read: o_sram_oe_n=0 and o_sram_dq_oe=0 throughout READ. i_addr_inc at cycle t -> address at t+1, data captured end of t+1, o_pix/o_pix_valid at t+2. Fixed latency 2; o_pix_valid is i_addr_inc delayed 2 while in READ.
- Bus turnaround: o_sram_dq_oe must be 0 in the first READ cycle after WRITE (FSM exit forces it low same edge).
- Reset mid-write: any pending write cycle is cancelled, we_n returns 1 next edge.

## Structure
- Package sram_frame_pkg: mode enum (IDLE, WRITE, READ), FRAME_PIX = N*M, WORD_WIDTH = 2*PIX_WIDTH.
- One sub-module natural: sram_read_pipe (2-stage address/data/byte-select pipeline with valid shift). Write packing and FSM stay in the top.

## Test plan
- Reset with i_WE_n=1, i_OE_n=1 -> all outputs at reset values, ce_n=1.
- WRITE, pixels 0x11,0x22 on consecutive valid cycles -> one cycle later addr=0, dq=0x2211, dq_oe=1, we_n=0 for one cycle only.
- Full write frame of N*M pixels -> last write addr=153599, o_frame_done pulses once, p back to 0.
- READ after writing 0x2211 at word 0, i_addr_inc high 2 cycles -> o_pix=0x11 then 0x22 at t+2, t+3, o_pix_valid for exactly 2 cycles.
- i_WE_n and i_OE_n both low -> WRITE behaviour, o_sram_oe_n stays 1.
- Drop i_WE_n high after 3 pixels -> word 0 written, third byte discarded, no further we_n pulse, dq_oe=0 next cycle.
